// File: rtl/mem_responder_pkg.sv
// Shared types for the data-memory responder: scalar aliases, FSM state
// encoding and the wait-state counter width.
package mem_responder_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;

    localparam int unsigned MEM_LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Word-organised storage with byte-lane synchronous writes and an
// asynchronous read port; contents are never cleared.
module mem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Byte-lane write; lanes with a clear enable keep their old contents
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/mem_responder.sv
// Stallable data-memory responder: one request at a time, programmable wait
// states, registered response with error flag for bad addresses.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        memwrite,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    input  logic [3:0]  be,
    output logic        busy,
    output logic        ready,
    output logic [31:0] readdata,
    output logic        err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [MEM_LAT_W-1:0] LAT_LOAD =
        (LATENCY > 0) ? MEM_LAT_W'(LATENCY - 1) : {MEM_LAT_W{1'b0}};

    mem_state_t           state_q, state_d;
    logic [MEM_LAT_W-1:0] cnt_q, cnt_d;
    u1                    we_q, we_d;
    u1                    bad_q, bad_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    u32                   wdata_q, wdata_d;
    logic [3:0]           be_q, be_d;
    u1                    busy_q, busy_d;
    u1                    ready_q, ready_d;
    u1                    err_q, err_d;
    u32                   rdata_q, rdata_d;

    u32 acc_off_s;
    u1  acc_bad_s;
    u32 rd_word_s;
    u1  mem_we_s;

    // Base-relative offset; misalignment is visible in its low bits because the base is aligned
    assign acc_off_s = dataaddr - BASE_ADDR;
    assign acc_bad_s = (acc_off_s[1:0] != 2'b00)
                    || (dataaddr < BASE_ADDR)
                    || ({2'b00, acc_off_s[31:2]} >= 32'(DEPTH_WORDS));

    // A write commits only at the end of a clean RESP cycle not hit by reset
    assign mem_we_s = (state_q == RESP) && we_q && !bad_q && reset;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk_i   (clk),
        .we_i    (mem_we_s),
        .be_i    (be_q),
        .widx_i  (idx_q),
        .wdata_i (wdata_q),
        .ridx_i  (idx_d),
        .rdata_o (rd_word_s)
    );

    // Next-state, request capture and next registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        bad_d   = bad_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = memwrite;
                    bad_d   = acc_bad_s;
                    idx_d   = acc_off_s[IDX_W+1:2];
                    wdata_d = writedata;
                    be_d    = be;
                    cnt_d   = LAT_LOAD;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == {MEM_LAT_W{1'b0}}) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - {{(MEM_LAT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == RESP);
        err_d   = ready_d && bad_d;
        if (ready_d && !bad_d && !we_d) begin
            rdata_d = rd_word_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {MEM_LAT_W{1'b0}};
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            wdata_q <= 32'h0000_0000;
            be_q    <= 4'h0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign readdata = rdata_q;

endmodule
